// File: rtl/dct_transpose_ctrl.sv
// dct_transpose_ctrl: FILL/DRAIN sequencer for the 8x8 transpose memory between the row and column DCT passes.
// Optional DCT_TRANSPOSE_CTRL_OUTREG_EN inserts a one-entry registered stage on the column output.
module dct_transpose_ctrl #(
  parameter int unsigned CW        = 12,
  parameter int unsigned N         = 8,
  parameter int unsigned BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*CW-1:0]      in_data,
  output logic                 tp_wr,
  output logic                 tp_rd,
  output logic [N*CW-1:0]      tp_in,
  input  logic [N*CW-1:0]      tp_ut,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*CW-1:0]      out_data,
  output logic                 block_done,
  output logic [BLK_CNT_W-1:0] blk_cnt,
  output logic                 busy
);
  localparam int unsigned DW = N * CW;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        row_cnt_q, row_cnt_d;
  logic [IW-1:0]        col_cnt_q, col_cnt_d;
  logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic                 block_done_q, block_done_d;
  logic                 blk_last;

  assign in_ready = (state_q == FILL);
  assign tp_wr    = in_valid & in_ready;
  assign tp_in    = in_data;

`ifdef DCT_TRANSPOSE_CTRL_OUTREG_EN
  logic          ov_q, ov_d;
  logic [DW-1:0] od_q, od_d;
  logic          olast_q, olast_d;

  // Load whenever the register is empty or is being emptied this cycle.
  assign tp_rd     = (state_q == DRAIN) & (~ov_q | out_ready);
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign blk_last  = ov_q & out_ready & olast_q;
`else
  assign out_valid = (state_q == DRAIN);
  assign tp_rd     = out_valid & out_ready;
  assign out_data  = tp_ut;
  assign blk_last  = tp_rd & (col_cnt_q == LAST);
`endif

  assign block_done = block_done_q;
  assign blk_cnt    = blk_cnt_q;
  assign busy       = (state_q != FILL) | (row_cnt_q != '0);

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    col_cnt_d    = col_cnt_q;
    blk_cnt_d    = blk_cnt_q;
    block_done_d = 1'b0;
`ifdef DCT_TRANSPOSE_CTRL_OUTREG_EN
    ov_d         = ov_q;
    od_d         = od_q;
    olast_d      = olast_q;
    if (tp_rd) begin
      ov_d    = 1'b1;
      od_d    = tp_ut;
      olast_d = (col_cnt_q == LAST);
    end else if (ov_q & out_ready) begin
      ov_d    = 1'b0;
      olast_d = 1'b0;
    end
`endif
    case (state_q)
      FILL: begin
        if (tp_wr) begin
          if (row_cnt_q == LAST) begin
            row_cnt_d = '0;
            col_cnt_d = '0;
            state_d   = DRAIN;
          end else begin
            row_cnt_d = row_cnt_q + IW'(1);
          end
        end
      end
      DRAIN: begin
        if (tp_rd) begin
          if (col_cnt_q == LAST) begin
            col_cnt_d = '0;
            state_d   = FILL;
          end else begin
            col_cnt_d = col_cnt_q + IW'(1);
          end
        end
      end
    endcase
    // Completion is counted when the last column leaves the block.
    if (blk_last) begin
      block_done_d = 1'b1;
      blk_cnt_d    = blk_cnt_q + BLK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      row_cnt_q    <= '0;
      col_cnt_q    <= '0;
      blk_cnt_q    <= '0;
      block_done_q <= 1'b0;
`ifdef DCT_TRANSPOSE_CTRL_OUTREG_EN
      ov_q         <= 1'b0;
      od_q         <= '0;
      olast_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      col_cnt_q    <= col_cnt_d;
      blk_cnt_q    <= blk_cnt_d;
      block_done_q <= block_done_d;
`ifdef DCT_TRANSPOSE_CTRL_OUTREG_EN
      ov_q         <= ov_d;
      od_q         <= od_d;
      olast_q      <= olast_d;
`endif
    end
  end

endmodule

// File: tb/tb_dct_transpose_ctrl.sv
// Self-checking bench for dct_transpose_ctrl with a behavioural transpose memory and a column scoreboard.
module tb_dct_transpose_ctrl;
  localparam int CW = 12;
  localparam int N  = 8;
  localparam int DW = N * CW;
`ifdef DCT_TRANSPOSE_CTRL_OUTREG_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, tp_wr, tp_rd, out_valid, out_ready, block_done, busy;
  logic [DW-1:0] in_data, tp_in, tp_ut, out_data;
  logic [15:0]   blk_cnt;
  logic          w_in_ready, w_tp_wr, w_tp_rd, w_out_valid, w_block_done, w_busy;
  logic [DW-1:0] w_tp_in, w_out_data;
  logic [1:0]    w_blk_cnt;

  always #5 clk = ~clk;

  dct_transpose_ctrl #(.CW(12), .N(8), .BLK_CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tp_wr(tp_wr), .tp_rd(tp_rd), .tp_in(tp_in), .tp_ut(tp_ut),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .block_done(block_done), .blk_cnt(blk_cnt), .busy(busy)
  );

  // Narrow-counter twin sees identical handshakes, so it can share the transpose model.
  dct_transpose_ctrl #(.CW(12), .N(8), .BLK_CNT_W(2)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .tp_wr(w_tp_wr), .tp_rd(w_tp_rd), .tp_in(w_tp_in), .tp_ut(tp_ut),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
    .block_done(w_block_done), .blk_cnt(w_blk_cnt), .busy(w_busy)
  );

  // Behavioural transpose memory: rows written in order, columns presented in order.
  logic [DW-1:0] mem [N];
  int wr_idx, rd_idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      wr_idx <= 0;
      rd_idx <= 0;
    end else if (tp_wr && !tp_rd) begin
      mem[wr_idx] <= tp_in;
      wr_idx      <= (wr_idx + 1) % N;
    end else if (tp_rd && !tp_wr) begin
      rd_idx <= (rd_idx + 1) % N;
    end
  end
  always_comb begin
    tp_ut = '0;
    for (int r = 0; r < N; r++) tp_ut[DW-1-CW*r -: CW] = mem[r][DW-1-CW*rd_idx -: CW];
  end

  logic [DW-1:0] row_q [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  logic [15:0]   cnt_q [$];
  logic [1:0]    cnt2_q [$];
  int n_vec = 0, n_err = 0;
  int cyc, n_wr, n_rd, n_both, n_unstable, n_blocked, n_done, first_ov, last_acc;
  bit hold_prev;
  logic [DW-1:0] hold_data;

  function automatic logic [CW-1:0] val(input int seed, input int r, input int c);
    return CW'(seed + 16 * r + c);
  endfunction

  // Queue the 8 rows of a block and the 8 columns the transpose must return.
  task automatic push_block(input int seed);
    logic [DW-1:0] v;
    for (int r = 0; r < N; r++) begin
      v = '0;
      for (int c = 0; c < N; c++) v[DW-1-CW*c -: CW] = val(seed, r, c);
      row_q.push_back(v);
    end
    for (int c = 0; c < N; c++) begin
      v = '0;
      for (int r = 0; r < N; r++) v[DW-1-CW*r -: CW] = val(seed, r, c);
      exp_q.push_back(v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    row_q.delete(); exp_q.delete(); got_q.delete(); cnt_q.delete(); cnt2_q.delete();
    cyc = 0; n_wr = 0; n_rd = 0; n_both = 0; n_unstable = 0; n_blocked = 0; n_done = 0;
    first_ov = 0; last_acc = 0; hold_prev = 1'b0; hold_data = '0;
  endtask

  // One clock: drive at the falling edge, observe handshakes just after, before the rising edge.
  task automatic cycle(input bit iv, input bit ordy);
    @(negedge clk);
    in_valid  = iv && (row_q.size() > 0);
    in_data   = (row_q.size() > 0) ? row_q[0] : '0;
    out_ready = ordy;
    #1;
    cyc++;
    if (tp_wr) n_wr++;
    if (tp_rd) n_rd++;
    if (tp_wr && tp_rd) n_both++;
    if (hold_prev && out_valid && out_data !== hold_data) n_unstable++;
    hold_prev = out_valid && !out_ready;
    hold_data = out_data;
    if (in_valid && !in_ready) n_blocked++;
    if (out_valid && first_ov == 0) first_ov = cyc;
    if (block_done) begin n_done++; cnt_q.push_back(blk_cnt); end
    if (w_block_done) cnt2_q.push_back(w_blk_cnt);
    if (in_valid && in_ready) begin void'(row_q.pop_front()); last_acc = cyc; end
    if (out_valid && out_ready) got_q.push_back(out_data);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (blk_cnt !== 16'd0) begin n_err++; $display("FAIL reset_blk_cnt got %0d want 0", blk_cnt); end
    n_vec++; if (block_done !== 1'b0) begin n_err++; $display("FAIL reset_block_done got %b want 0", block_done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] c0, c7, g, e;
    c0 = 96'h000_010_020_030_040_050_060_070;
    c7 = 96'h007_017_027_037_047_057_067_077;
    do_reset();
    push_block(0);
    for (int k = 0; k < 60 && got_q.size() < 8; k++) cycle(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1);
    n_vec++;
    if (got_q.size() != 8) begin
      n_err++; $display("FAIL basic_count got %0d want 8", got_q.size());
    end else begin
      n_vec++; if (got_q[0] !== c0) begin n_err++; $display("FAIL basic_col0 got %h want %h", got_q[0], c0); end
      n_vec++; if (got_q[7] !== c7) begin n_err++; $display("FAIL basic_col7 got %h want %h", got_q[7], c7); end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_vec++; if (g !== e) begin n_err++; $display("FAIL basic_col got %h want %h", g, e); end
    end
    n_vec++; if (n_done != 1) begin n_err++; $display("FAIL basic_done got %0d want 1", n_done); end
    n_vec++; if (blk_cnt !== 16'd1) begin n_err++; $display("FAIL basic_blk_cnt got %0d want 1", blk_cnt); end
    n_vec++; if (first_ov - last_acc != 1 + XL) begin
      n_err++; $display("FAIL basic_latency got %0d want %0d", first_ov - last_acc, 1 + XL);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] g, e;
    do_reset();
    push_block(12'h400);
    for (int k = 0; k < 800 && got_q.size() < 8; k++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    n_vec++; if (got_q.size() != 8) begin n_err++; $display("FAIL bp_count got %0d want 8", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_vec++; if (g !== e) begin n_err++; $display("FAIL bp_col got %h want %h", g, e); end
    end
    n_vec++; if (n_wr != 8) begin n_err++; $display("FAIL bp_tp_wr got %0d want 8", n_wr); end
    n_vec++; if (n_rd != 8) begin n_err++; $display("FAIL bp_tp_rd got %0d want 8", n_rd); end
    n_vec++; if (n_unstable != 0) begin n_err++; $display("FAIL bp_stable got %0d want 0", n_unstable); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] g, e;
    int t_end;
    do_reset();
    push_block(12'h100); push_block(12'h200); push_block(12'h300);
    t_end = 0;
    for (int k = 0; k < 200 && got_q.size() < 24; k++) begin
      cycle(1'b1, 1'b1);
      if (got_q.size() == 24) t_end = cyc;
    end
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1);
    n_vec++; if (t_end != 48 + XL) begin n_err++; $display("FAIL b2b_cycles got %0d want %0d", t_end, 48 + XL); end
    n_vec++; if (got_q.size() != 24) begin n_err++; $display("FAIL b2b_count got %0d want 24", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_vec++; if (g !== e) begin n_err++; $display("FAIL b2b_col got %h want %h", g, e); end
    end
    n_vec++; if (n_done != 3) begin n_err++; $display("FAIL b2b_done got %0d want 3", n_done); end
    n_vec++; if (blk_cnt !== 16'd3) begin n_err++; $display("FAIL b2b_blk_cnt got %0d want 3", blk_cnt); end
    n_vec++; if (n_both != 0) begin n_err++; $display("FAIL b2b_wr_rd_overlap got %0d want 0", n_both); end
  endtask

  task automatic test_reset_mid_block();
    logic [DW-1:0] g, e;
    do_reset();
    push_block(12'h100);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1);
    #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b want 1", busy); end
    do_reset();
    push_block(12'h800);
    for (int k = 0; k < 60 && got_q.size() < 8; k++) cycle(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1);
    n_vec++; if (got_q.size() != 8) begin n_err++; $display("FAIL mid_count got %0d want 8", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_vec++; if (g !== e) begin n_err++; $display("FAIL mid_col got %h want %h", g, e); end
    end
    n_vec++; if (n_done != 1) begin n_err++; $display("FAIL mid_done got %0d want 1", n_done); end
    n_vec++; if (blk_cnt !== 16'd1) begin n_err++; $display("FAIL mid_blk_cnt got %0d want 1", blk_cnt); end
  endtask

  task automatic test_input_in_drain();
    logic [DW-1:0] g, e;
    int k_acc;
    do_reset();
    push_block(12'h300);
    row_q.push_back(96'hABC_ABC_ABC_ABC_ABC_ABC_ABC_ABC);
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0);
    n_vec++; if (n_blocked != 10) begin n_err++; $display("FAIL drain_in_ready_low got %0d want 10", n_blocked); end
    n_vec++; if (n_wr != 8) begin n_err++; $display("FAIL drain_no_wr got %0d want 8", n_wr); end
    k_acc = 0;
    for (int k = 1; k <= 30 && k_acc == 0; k++) begin
      cycle(1'b1, 1'b1);
      if (row_q.size() == 0) k_acc = k;
    end
    n_vec++; if (k_acc != 9 - XL) begin n_err++; $display("FAIL drain_accept_cycle got %0d want %0d", k_acc, 9 - XL); end
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1);
    n_vec++; if (got_q.size() != 8) begin n_err++; $display("FAIL drain_count got %0d want 8", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_vec++; if (g !== e) begin n_err++; $display("FAIL drain_col got %h want %h", g, e); end
    end
  endtask

  task automatic test_blk_wrap();
    logic [1:0] want [5];
    logic [1:0] g2;
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0; want[4] = 2'd1;
    do_reset();
    for (int b = 0; b < 5; b++) push_block(12'h900 + 16 * b);
    for (int k = 0; k < 200 && got_q.size() < 40; k++) cycle(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1);
    n_vec++; if (cnt2_q.size() != 5) begin n_err++; $display("FAIL wrap_pulses got %0d want 5", cnt2_q.size()); end
    for (int i = 0; i < 5 && cnt2_q.size() > 0; i++) begin
      g2 = cnt2_q.pop_front();
      n_vec++; if (g2 !== want[i]) begin n_err++; $display("FAIL wrap_blk_cnt[%0d] got %0d want %0d", i, g2, want[i]); end
    end
    n_vec++; if (blk_cnt !== 16'd5) begin n_err++; $display("FAIL wrap_wide_blk_cnt got %0d want 5", blk_cnt); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_block();
    test_input_in_drain();
    test_blk_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
